// File: rtl/axi_write_slave_burst.sv
`default_nettype none
//==============================================================================
// Module   : axi_write_slave_burst
// Brief    : AXI3 write slave; one burst at a time, beats buffered to a mem port
// Revision : 1.0 - initial release
//==============================================================================
module axi_write_slave_burst #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ID_W-1:0]     WID,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  output logic [DATA_W/8-1:0] mem_strb,
  output logic                mem_last,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                busy
);

  localparam int c_STRB_W = DATA_W / 8;
  localparam int c_IDX_W  = $clog2(FIFO_DEPTH);
  localparam int c_PTR_W  = c_IDX_W + 1;

  localparam logic [7:0] c_BUS_BYTES = 8'(c_STRB_W);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_DATA  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  localparam logic [1:0] c_FIXED = 2'b00;
  localparam logic [1:0] c_INCR  = 2'b01;
  localparam logic [1:0] c_WRAP  = 2'b10;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              r_awready;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_err;
  logic [3:0]        r_cnt;

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_IDX_W-1:0] w_wr_idx;
  logic [c_IDX_W-1:0] w_rd_idx;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [c_STRB_W-1:0] r_fifo_strb [FIFO_DEPTH];
  logic                r_fifo_last [FIFO_DEPTH];

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_last_beat;
  logic              w_beat_err;
  logic [7:0]        w_aw_bytes;
  logic              w_aw_wrap_len_ok;
  logic              w_aw_burst_bad;
  logic              w_aw_err;
  logic [1:0]        w_aw_burst_eff;
  logic [ADDR_W-1:0] w_bytes;
  logic [ADDR_W-1:0] w_total;
  logic [ADDR_W-1:0] w_mask;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_next_addr;

  // Burst-level checks are resolved once at AW time; illegal burst kinds fall back to INCR
  assign w_aw_bytes       = 8'd1 << AWSIZE;
  assign w_aw_wrap_len_ok = (AWLEN == 4'd1) || (AWLEN == 4'd3) ||
                            (AWLEN == 4'd7) || (AWLEN == 4'd15);
  assign w_aw_burst_bad   = (AWBURST == 2'b11) ||
                            ((AWBURST == c_WRAP) && !w_aw_wrap_len_ok);
  assign w_aw_err         = w_aw_burst_bad || (w_aw_bytes > c_BUS_BYTES);
  assign w_aw_burst_eff   = w_aw_burst_bad ? c_INCR : AWBURST;

  assign w_aw_hs     = AWVALID && r_awready;
  assign w_w_hs      = WVALID && WREADY;
  assign w_last_beat = (r_cnt == r_len);
  assign w_beat_err  = (WLAST != w_last_beat) || (WID != r_id);

  assign w_bytes = ADDR_W'(1) << r_size;
  assign w_total = w_bytes * (ADDR_W'(r_len) + ADDR_W'(1));
  assign w_mask  = w_total - ADDR_W'(1);
  assign w_inc   = r_addr + w_bytes;

  always_comb begin
    w_next_addr = w_inc;
    case (r_burst)
      c_FIXED: w_next_addr = r_addr;
      c_WRAP:  w_next_addr = (r_addr & ~w_mask) | (w_inc & w_mask);
      default: w_next_addr = w_inc;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (w_aw_hs)                w_state_next = c_DATA;
      c_DATA:  if (w_w_hs && w_last_beat) w_state_next = c_DRAIN;
      c_DRAIN: if (w_empty)                w_state_next = c_RESP;
      c_RESP:  if (BREADY)                 w_state_next = c_IDLE;
      default:                             w_state_next = c_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= c_IDLE;
      r_awready <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= c_FIXED;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_awready <= (w_state_next == c_IDLE);
      if (r_state == c_IDLE && w_aw_hs) begin
        r_id    <= AWID;
        r_addr  <= AWADDR;
        r_len   <= AWLEN;
        r_size  <= AWSIZE;
        r_burst <= w_aw_burst_eff;
        r_err   <= w_aw_err;
        r_cnt   <= '0;
      end else if (r_state == c_DATA && w_w_hs) begin
        r_cnt  <= r_cnt + 4'd1;
        r_addr <= w_next_addr;
        if (w_beat_err) r_err <= 1'b1;
      end
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign w_wr_idx = r_wr_ptr[c_IDX_W-1:0];
  assign w_rd_idx = r_rd_ptr[c_IDX_W-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]) && (w_wr_idx == w_rd_idx);
  assign w_push   = w_w_hs;
  assign w_pop    = !w_empty && mem_ready;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_fifo_addr[w_wr_idx] <= r_addr;
      r_fifo_data[w_wr_idx] <= WDATA;
      r_fifo_strb[w_wr_idx] <= WSTRB;
      r_fifo_last[w_wr_idx] <= w_last_beat;
    end
  end

  assign AWREADY = r_awready;
  assign WREADY  = (r_state == c_DATA) && !w_full;
  assign BVALID  = (r_state == c_RESP);
  assign BID     = BVALID ? r_id : '0;
  assign BRESP   = (BVALID && r_err) ? 2'b10 : 2'b00;
  assign busy    = (r_state != c_IDLE);

  // Head fields are forced to zero while empty so storage needs no reset
  assign mem_valid = !w_empty;
  assign mem_addr  = w_empty ? '0   : r_fifo_addr[w_rd_idx];
  assign mem_data  = w_empty ? '0   : r_fifo_data[w_rd_idx];
  assign mem_strb  = w_empty ? '0   : r_fifo_strb[w_rd_idx];
  assign mem_last  = w_empty ? 1'b0 : r_fifo_last[w_rd_idx];

endmodule
`default_nettype wire

// File: tb/tb_axi_write_slave_burst.sv
`default_nettype none
//==============================================================================
// Module   : tb_axi_write_slave_burst
// Brief    : Directed and randomized bursts checked against a queue-based model
// Revision : 1.0 - initial release
//==============================================================================
module tb_axi_write_slave_burst;

  logic        ACLK   = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  AWID   = '0;
  logic [31:0] AWADDR = '0;
  logic [3:0]  AWLEN  = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [3:0]  WID    = '0;
  logic [31:0] WDATA  = '0;
  logic [3:0]  WSTRB  = '0;
  logic        WLAST  = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_strb;
  logic        mem_last;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic        busy;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks   = 0;
  int    n_errors   = 0;
  int    cyc        = 0;
  bit    rand_ready = 1'b0;

  axi_write_slave_burst #(
    .DATA_W(32), .ADDR_W(32), .ID_W(4), .FIFO_DEPTH(4)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_strb(mem_strb),
    .mem_last(mem_last), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
    if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Address of beat i computed directly from the start address (no iteration)
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                            input int size, input int burst, input int i);
    logic [31:0] bytes;
    logic [31:0] total;
    logic [31:0] base;
    int b;
    b     = burst;
    bytes = 32'd1 << size;
    if (b == 3 || (b == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))) b = 1;
    case (b)
      0: return a;
      2: begin
        total = bytes * (len + 1);
        base  = a - (a % total);
        return base + ((a - base + bytes * i) % total);
      end
      default: return a + bytes * i;
    endcase
  endfunction

  always @(negedge ACLK) begin
    beat_t e;
    if (!ARESET && mem_valid && mem_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("mem_unexpected", {31'd0, mem_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("mem_addr", mem_addr, e.addr);
        check_eq("mem_data", mem_data, e.data);
        check_eq("mem_strb", mem_strb, e.strb);
        check_eq("mem_last", mem_last, e.last);
      end
    end
  end

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    while (!AWREADY && n < 200) begin step(); n++; end
    if (!AWREADY) check_eq("aw_timeout", AWREADY, 1);
    step();
    AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [3:0] id, input logic [31:0] data,
                        input logic [3:0] strb, input logic last);
    int n = 0;
    WID = id; WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    while (!WREADY && n < 200) begin step(); n++; end
    if (!WREADY) check_eq("w_timeout", WREADY, 1);
    step();
  endtask

  // Handshake edge is followed by 2 more edges before BVALID is visible (3rd cycle)
  task automatic b_wait(input logic [3:0] id, input logic [1:0] resp, input int exp_lat);
    int n = 0;
    int d;
    while (!BVALID && n < 200) begin step(); n++; end
    check_eq("b_valid", BVALID, 1);
    if (exp_lat >= 0) check_eq("b_latency", n, exp_lat);
    check_eq("b_id", BID, id);
    check_eq("b_resp", BRESP, resp);
    check_eq("drained", exp_q.size(), 0);
    d = $urandom_range(0, 2);
    repeat (d) step();
    check_eq("b_hold", {BVALID, BID, BRESP}, {1'b1, id, resp});
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    check_eq("b_done", {BVALID, AWREADY}, 2'b01);
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int last_err_beat, input int wid_err_beat, input int exp_lat);
    int ilen;
    bit err;
    int c0;
    ilen = len;
    err  = ((32'd1 << size) > 32'd4) || (burst == 2'b11) ||
           (burst == 2'b10 && !(ilen == 1 || ilen == 3 || ilen == 7 || ilen == 15)) ||
           (last_err_beat >= 0) || (wid_err_beat >= 0);
    aw_send(id, addr, len, size, burst);
    c0 = cyc;
    for (int i = 0; i <= ilen; i++) begin
      beat_t b;
      b.addr = beat_addr(addr, ilen, size, burst, i);
      b.data = $urandom;
      b.strb = 4'($urandom_range(0, 15));
      b.last = (i == ilen);
      w_beat((i == wid_err_beat) ? (id ^ 4'h5) : id, b.data, b.strb, b.last ^ (i == last_err_beat));
      exp_q.push_back(b);
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    if (exp_lat >= 0) check_eq("w_throughput", cyc - c0, ilen + 1);
    b_wait(id, err ? 2'b10 : 2'b00, exp_lat);
  endtask

  initial begin
    beat_t bt [8];
    logic  seen;

    repeat (3) @(posedge ACLK);
    #1;
    check_eq("rst_outputs", {AWREADY, WREADY, BVALID, mem_valid, busy, BID, BRESP, mem_last}, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    ARESET = 1'b0;
    step();
    check_eq("rst_awready", {AWREADY, busy}, 2'b10);

    // INCR 0x100 x4 with mem_ready high: latency and throughput checked
    mem_ready = 1'b1;
    run_burst(4'hA, 32'h100, 4'd3, 3'd2, 2'b01, -1, -1, 2);
    // WRAP 0x38 x4
    run_burst(4'h2, 32'h38, 4'd3, 3'd2, 2'b10, -1, -1, 2);
    // FIXED 0x20 x3
    run_burst(4'h7, 32'h20, 4'd2, 3'd2, 2'b00, -1, -1, 2);

    // INCR x8 with mem_ready low: FIFO fills after 4 beats
    mem_ready = 1'b0;
    aw_send(4'h3, 32'h200, 4'd7, 3'd2, 2'b01);
    for (int i = 0; i < 8; i++) begin
      bt[i].addr = beat_addr(32'h200, 7, 2, 1, i);
      bt[i].data = $urandom;
      bt[i].strb = 4'($urandom_range(0, 15));
      bt[i].last = (i == 7);
    end
    for (int i = 0; i < 4; i++) begin
      w_beat(4'h3, bt[i].data, bt[i].strb, bt[i].last);
      exp_q.push_back(bt[i]);
    end
    check_eq("wready_full", WREADY, 0);
    WDATA = bt[4].data; WSTRB = bt[4].strb; WLAST = bt[4].last;
    seen = 1'b0;
    repeat (6) begin step(); seen |= WREADY; end
    check_eq("wready_stall", seen, 0);
    check_eq("head_hold", {mem_valid, mem_addr}, {1'b1, bt[0].addr});
    mem_ready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      w_beat(4'h3, bt[i].data, bt[i].strb, bt[i].last);
      exp_q.push_back(bt[i]);
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    b_wait(4'h3, 2'b00, -1);

    // early WLAST on beat 2, WID mismatch on beat 3
    run_burst(4'h9, 32'h400, 4'd3, 3'd2, 2'b01, 2, 3, -1);

    // reset after two beats
    mem_ready = 1'b0;
    aw_send(4'h4, 32'h600, 4'd7, 3'd2, 2'b01);
    for (int i = 0; i < 2; i++) begin
      bt[i].addr = beat_addr(32'h600, 7, 2, 1, i);
      bt[i].data = $urandom;
      bt[i].strb = 4'hF;
      bt[i].last = 1'b0;
      w_beat(4'h4, bt[i].data, bt[i].strb, bt[i].last);
      exp_q.push_back(bt[i]);
    end
    check_eq("pre_reset_valid", mem_valid, 1);
    ARESET = 1'b1;
    #1;
    check_eq("midrst_outputs", {AWREADY, WREADY, BVALID, mem_valid, busy, BID, BRESP, mem_last}, 0);
    check_eq("midrst_mem_addr", mem_addr, 0);
    WVALID = 1'b0;
    exp_q.delete();
    step();
    step();
    ARESET = 1'b0;
    mem_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin step(); seen |= BVALID | mem_valid; end
    check_eq("no_resp_after_rst", seen, 0);
    run_burst(4'h5, 32'h800, 4'd3, 3'd2, 2'b01, -1, -1, 2);

    // randomized bursts with random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      logic [3:0] len;
      int le, we;
      len = 4'($urandom_range(0, 15));
      le  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      we  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      run_burst(4'($urandom), $urandom, len, 3'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), le, we, -1);
    end
    rand_ready = 1'b0;
    mem_ready  = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
